// File: rtl/rst_cipher_pkg.sv
// Shared types and constants for the RST cipher sequencer: controller state
// encoding plus key/character/pair widths and the null filler values.
package rst_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_ISSUE = 3'd1,
    KEY_CHECK = 3'd2,
    RUN       = 3'd3,
    WAIT      = 3'd4,
    OUT       = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } ctrl_state_t;

  localparam int KEY_CHARS = 12;
  localparam int CHAR_W    = 8;
  localparam int KEY_W     = KEY_CHARS * CHAR_W;
  localparam int PAIR_W    = 2 * CHAR_W;

  localparam logic [CHAR_W-1:0] NUL_CHAR = 8'h00;
  localparam logic [PAIR_W-1:0] NUL_PAIR = 16'h0000;

endpackage

// File: rtl/rst_resp_timer.sv
// Response timer: counts enabled cycles from a clear, saturating at LIMIT.
// expired_o flags the cycle whose closing edge brings the count to LIMIT.
module rst_resp_timer #(
  parameter int LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         enable_i,
  output logic [$clog2(LIMIT+1)-1:0]   count_o,
  output logic                         expired_o
);

  localparam int TW = $clog2(LIMIT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != TW'(LIMIT))) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = enable_i && !clear_i && (count_q == TW'(LIMIT - 1));

endmodule

// File: rtl/rst_cipher_ctrl.sv
// Sequencer in front of the RST encryption core: key load/check, one char at a
// time to the core, ciphertext pairs out with backpressure. Option: RST_SKIP_INVALID_EN.
module rst_cipher_ctrl
  import rst_cipher_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int RESP_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [CHAR_W-1:0]    ptx_in,
  input  logic                 ptx_valid,
  input  logic                 ptx_last,
  output logic                 ptx_ready,
  output logic [PAIR_W-1:0]    ctx_out,
  output logic                 ctx_valid,
  output logic                 ctx_last,
  input  logic                 ctx_ready,
  output logic [KEY_W-1:0]     core_key,
  output logic [CHAR_W-1:0]    core_ptx_char,
  output logic                 core_ptxt_valid,
  input  logic [PAIR_W-1:0]    core_sub_str,
  input  logic                 core_ctxt_ready,
  input  logic                 core_err_invalid_key,
  input  logic                 core_err_invalid_ptx_char,
  output logic                 err_key,
  output logic                 err_ptx,
  output logic                 err_timeout,
  output logic                 busy,
  output logic [CNT_W-1:0]     char_count,
  output ctrl_state_t          dbg_state
);

  localparam int              TMR_W   = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; valid never waits on ready, and ctx_out/ctx_last stay stable
  // while ctx_valid is high and ctx_ready is low.

  ctrl_state_t         state_q, state_d;
  logic [KEY_W-1:0]    core_key_q, core_key_d;
  logic [CHAR_W-1:0]   ptx_char_q, ptx_char_d;
  logic                ptxt_valid_q, ptxt_valid_d;
  logic                last_q, last_d;
  logic [PAIR_W-1:0]   ctx_out_q, ctx_out_d;
  logic                ctx_valid_q, ctx_valid_d;
  logic                ctx_last_q, ctx_last_d;
  logic                err_key_q, err_key_d;
  logic                err_ptx_q, err_ptx_d;
  logic                err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]    char_count_q, char_count_d;

  logic                tmr_clear;
  logic                tmr_en;
  logic [TMR_W-1:0]    tmr_count;
  logic                tmr_expired;
  logic                key_take;

  rst_resp_timer #(
    .LIMIT (RESP_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .count_o   (tmr_count),
    .expired_o (tmr_expired)
  );

  // ERROR accepts a new key without raising key_ready.
  assign key_take = key_valid && ((state_q == IDLE) || (state_q == ERROR));

  always_comb begin
    state_d       = state_q;
    core_key_d    = core_key_q;
    ptx_char_d    = ptx_char_q;
    ptxt_valid_d  = 1'b0;
    last_d        = last_q;
    ctx_out_d     = ctx_out_q;
    ctx_valid_d   = ctx_valid_q;
    ctx_last_d    = ctx_last_q;
    err_key_d     = err_key_q;
    err_ptx_d     = err_ptx_q;
    err_timeout_d = err_timeout_q;
    char_count_d  = char_count_q;
    tmr_clear     = 1'b1;
    tmr_en        = 1'b0;

    case (state_q)
      IDLE: ;
      KEY_ISSUE: state_d = KEY_CHECK;
      KEY_CHECK: begin
        tmr_clear = 1'b0;
        tmr_en    = 1'b1;
        if (core_err_invalid_key) begin
          err_key_d = 1'b1;
          state_d   = ERROR;
        end else if (tmr_count == TMR_W'(1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ptx_valid) begin
          ptx_char_d   = ptx_in;
          last_d       = ptx_last;
          ptxt_valid_d = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        tmr_clear = 1'b0;
        tmr_en    = 1'b1;
        if (core_err_invalid_ptx_char) begin
          err_ptx_d = 1'b1;
`ifdef RST_SKIP_INVALID_EN
          // A skipped last char still closes the frame with a null beat.
          if (last_q) begin
            ctx_out_d   = NUL_PAIR;
            ctx_valid_d = 1'b1;
            ctx_last_d  = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = RUN;
          end
`else
          state_d = ERROR;
`endif
        end else if (core_ctxt_ready) begin
          ctx_out_d   = core_sub_str;
          ctx_valid_d = 1'b1;
          ctx_last_d  = last_q;
          if (char_count_q != CNT_MAX) begin
            char_count_d = char_count_q + CNT_W'(1);
          end
          state_d = OUT;
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ERROR;
        end
      end
      OUT: begin
        if (ctx_ready) begin
          ctx_valid_d = 1'b0;
          ctx_last_d  = 1'b0;
          state_d     = ctx_last_q ? DONE : RUN;
        end
      end
      DONE:  state_d = IDLE;
      ERROR: ctx_valid_d = 1'b0;
      default: state_d = IDLE;
    endcase

    if (key_take) begin
      core_key_d    = key_in;
      err_key_d     = 1'b0;
      err_ptx_d     = 1'b0;
      err_timeout_d = 1'b0;
      char_count_d  = '0;
      ctx_valid_d   = 1'b0;
      ctx_last_d    = 1'b0;
      state_d       = KEY_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      core_key_q    <= '0;
      ptx_char_q    <= NUL_CHAR;
      ptxt_valid_q  <= 1'b0;
      last_q        <= 1'b0;
      ctx_out_q     <= NUL_PAIR;
      ctx_valid_q   <= 1'b0;
      ctx_last_q    <= 1'b0;
      err_key_q     <= 1'b0;
      err_ptx_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      char_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      core_key_q    <= core_key_d;
      ptx_char_q    <= ptx_char_d;
      ptxt_valid_q  <= ptxt_valid_d;
      last_q        <= last_d;
      ctx_out_q     <= ctx_out_d;
      ctx_valid_q   <= ctx_valid_d;
      ctx_last_q    <= ctx_last_d;
      err_key_q     <= err_key_d;
      err_ptx_q     <= err_ptx_d;
      err_timeout_q <= err_timeout_d;
      char_count_q  <= char_count_d;
    end
  end

  assign key_ready       = (state_q == IDLE);
  assign ptx_ready       = (state_q == RUN);
  assign busy            = (state_q != IDLE);
  assign core_key        = core_key_q;
  assign core_ptx_char   = ptx_char_q;
  assign core_ptxt_valid = ptxt_valid_q;
  assign ctx_out         = ctx_out_q;
  assign ctx_valid       = ctx_valid_q;
  assign ctx_last        = ctx_last_q;
  assign err_key         = err_key_q;
  assign err_ptx         = err_ptx_q;
  assign err_timeout     = err_timeout_q;
  assign char_count      = char_count_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_rst_cipher_ctrl.sv
// Directed bench for rst_cipher_ctrl; the bench plays the encryption core.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rst_cipher_ctrl;
  import rst_cipher_pkg::*;

  localparam int CNT_W        = 8;
  localparam int RESP_TIMEOUT = 4;

  localparam logic [95:0] KEY_A = 96'h4C4B4A494847464544434241; // "ABCDEFGHIJKL"
  localparam logic [95:0] KEY_M = 96'h5857565554535251504F4E4D; // "MNOPQRSTUVWX"

  logic              clk = 1'b0;
  logic              rst;
  logic [95:0]       key_in;
  logic              key_valid;
  logic              key_ready;
  logic [7:0]        ptx_in;
  logic              ptx_valid;
  logic              ptx_last;
  logic              ptx_ready;
  logic [15:0]       ctx_out;
  logic              ctx_valid;
  logic              ctx_last;
  logic              ctx_ready;
  logic [95:0]       core_key;
  logic [7:0]        core_ptx_char;
  logic              core_ptxt_valid;
  logic [15:0]       core_sub_str;
  logic              core_ctxt_ready;
  logic              core_err_invalid_key;
  logic              core_err_invalid_ptx_char;
  logic              err_key;
  logic              err_ptx;
  logic              err_timeout;
  logic              busy;
  logic [CNT_W-1:0]  char_count;
  ctrl_state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rst_cipher_ctrl #(
    .CNT_W        (CNT_W),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .key_in                    (key_in),
    .key_valid                 (key_valid),
    .key_ready                 (key_ready),
    .ptx_in                    (ptx_in),
    .ptx_valid                 (ptx_valid),
    .ptx_last                  (ptx_last),
    .ptx_ready                 (ptx_ready),
    .ctx_out                   (ctx_out),
    .ctx_valid                 (ctx_valid),
    .ctx_last                  (ctx_last),
    .ctx_ready                 (ctx_ready),
    .core_key                  (core_key),
    .core_ptx_char             (core_ptx_char),
    .core_ptxt_valid           (core_ptxt_valid),
    .core_sub_str              (core_sub_str),
    .core_ctxt_ready           (core_ctxt_ready),
    .core_err_invalid_key      (core_err_invalid_key),
    .core_err_invalid_ptx_char (core_err_invalid_ptx_char),
    .err_key                   (err_key),
    .err_ptx                   (err_ptx),
    .err_timeout               (err_timeout),
    .busy                      (busy),
    .char_count                (char_count),
    .dbg_state                 (dbg_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".state"}, dbg_state, IDLE);
    chk({tag, ".key_ready"}, key_ready, 1'b1);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".ptx_ready"}, ptx_ready, 1'b0);
    chk({tag, ".ctx_valid"}, ctx_valid, 1'b0);
    chk({tag, ".ctx_last"}, ctx_last, 1'b0);
    chk({tag, ".ctx_out"}, ctx_out, 16'h0000);
    chk({tag, ".core_key"}, core_key, 96'h0);
    chk({tag, ".core_ptxt_valid"}, core_ptxt_valid, 1'b0);
    chk({tag, ".errs"}, {err_key, err_ptx, err_timeout}, 3'b000);
    chk({tag, ".char_count"}, char_count, 8'd0);
  endtask

  // Key handshake, then ptx_ready must rise on the 4th cycle counted from it.
  task automatic key_to_run(input logic [95:0] k, input string tag);
    key_in    = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk({tag, ".issue_state"}, dbg_state, KEY_ISSUE);
    chk({tag, ".core_key"}, core_key, k);
    chk({tag, ".busy"}, busy, 1'b1);
    chk({tag, ".count_clr"}, char_count, 8'd0);
    chk({tag, ".ptx_ready1"}, ptx_ready, 1'b0);
    step();
    chk({tag, ".check_state"}, dbg_state, KEY_CHECK);
    chk({tag, ".ptx_ready2"}, ptx_ready, 1'b0);
    step();
    chk({tag, ".ptx_ready3"}, ptx_ready, 1'b0);
    step();
    chk({tag, ".ptx_ready4"}, ptx_ready, 1'b1);
    chk({tag, ".run_state"}, dbg_state, RUN);
    chk({tag, ".errs"}, {err_key, err_ptx, err_timeout}, 3'b000);
  endtask

  task automatic send_char(input logic [7:0] c, input logic last, input string tag);
    ptx_in    = c;
    ptx_valid = 1'b1;
    ptx_last  = last;
    step();
    ptx_valid = 1'b0;
    ptx_last  = 1'b0;
    chk({tag, ".wait_state"}, dbg_state, WAIT);
    chk({tag, ".strobe"}, core_ptxt_valid, 1'b1);
    chk({tag, ".core_char"}, core_ptx_char, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_in = '0; key_valid = 1'b0;
    ptx_in = '0; ptx_valid = 1'b0; ptx_last = 1'b0;
    ctx_ready = 1'b0;
    core_sub_str = '0; core_ctxt_ready = 1'b0;
    core_err_invalid_key = 1'b0; core_err_invalid_ptx_char = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("rst");

    // Key accept and 3-char message, first pair held by backpressure
    key_to_run(KEY_A, "keyA");
    send_char(8'h61, 1'b0, "ch_a");
    step();
    chk("ch_a.strobe_off", core_ptxt_valid, 1'b0);
    core_sub_str = 16'h4131; core_ctxt_ready = 1'b1;
    step();
    core_ctxt_ready = 1'b0;
    chk("ch_a.state", dbg_state, OUT);
    chk("ch_a.beat", {ctx_valid, ctx_last, ctx_out}, {1'b1, 1'b0, 16'h4131});
    chk("ch_a.count", char_count, 8'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold.beat", {ctx_valid, ctx_last, ctx_out}, {1'b1, 1'b0, 16'h4131});
      chk("hold.ptx_ready", ptx_ready, 1'b0);
      chk("hold.strobe", core_ptxt_valid, 1'b0);
    end
    ctx_ready = 1'b1;
    step();
    chk("ch_a.xfer_valid", ctx_valid, 1'b0);
    chk("ch_a.back_run", ptx_ready, 1'b1);

    send_char(8'h62, 1'b0, "ch_b");
    core_sub_str = 16'h4142; core_ctxt_ready = 1'b1;
    step();
    core_ctxt_ready = 1'b0;
    chk("ch_b.beat", {ctx_valid, ctx_last, ctx_out}, {1'b1, 1'b0, 16'h4142});
    chk("ch_b.count", char_count, 8'd2);
    step();
    chk("ch_b.run", dbg_state, RUN);
    chk("ch_b.xfer_valid", ctx_valid, 1'b0);

    send_char(8'h63, 1'b1, "ch_c");
    step();
    core_sub_str = 16'h4133; core_ctxt_ready = 1'b1;
    step();
    core_ctxt_ready = 1'b0;
    chk("ch_c.beat", {ctx_valid, ctx_last, ctx_out}, {1'b1, 1'b1, 16'h4133});
    chk("ch_c.count", char_count, 8'd3);
    step();
    chk("ch_c.done", dbg_state, DONE);
    chk("ch_c.valid_off", {ctx_valid, ctx_last}, 2'b00);
    step();
    chk("ch_c.idle", {dbg_state, busy, key_ready}, {IDLE, 1'b0, 1'b1});
    chk("ch_c.count_hold", char_count, 8'd3);

    // Silent core: err_timeout exactly RESP_TIMEOUT cycles after the strobe
    key_to_run(KEY_M, "keyM");
    send_char(8'h64, 1'b0, "ch_d");
    chk("tmo.w0", err_timeout, 1'b0);
    for (int i = 1; i < RESP_TIMEOUT; i++) begin
      step();
      chk("tmo.wait", {dbg_state, err_timeout}, {WAIT, 1'b0});
    end
    step();
    chk("tmo.flag", err_timeout, 1'b1);
    chk("tmo.state", dbg_state, ERROR);
    chk("tmo.ptx_ready", ptx_ready, 1'b0);
    chk("tmo.ctx_valid", ctx_valid, 1'b0);

    // Restart from ERROR, then the core rejects the key
    key_in = KEY_A; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("kerr.issue", dbg_state, KEY_ISSUE);
    chk("kerr.tmo_clr", err_timeout, 1'b0);
    step();
    chk("kerr.check", dbg_state, KEY_CHECK);
    core_err_invalid_key = 1'b1;
    step();
    core_err_invalid_key = 1'b0;
    chk("kerr.flag", err_key, 1'b1);
    chk("kerr.state", dbg_state, ERROR);
    chk("kerr.ptx_ready", ptx_ready, 1'b0);
    step();
    chk("kerr.stay", {dbg_state, ptx_ready, err_key}, {ERROR, 1'b0, 1'b1});
    key_to_run(KEY_A, "keyR");

    // One good char, then reset while waiting on the core
    send_char(8'h65, 1'b0, "ch_e");
    core_sub_str = 16'h4135; core_ctxt_ready = 1'b1;
    step();
    core_ctxt_ready = 1'b0;
    chk("ch_e.count", char_count, 8'd1);
    step();
    chk("ch_e.run", dbg_state, RUN);
    send_char(8'h66, 1'b0, "ch_f");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst_wait");

    // Core char error with a simultaneous result on a last char
    key_to_run(KEY_A, "keyS");
    send_char(8'h67, 1'b1, "ch_g");
    core_err_invalid_ptx_char = 1'b1; core_ctxt_ready = 1'b1; core_sub_str = 16'h4137;
    step();
    core_err_invalid_ptx_char = 1'b0; core_ctxt_ready = 1'b0;
    chk("perr.flag", err_ptx, 1'b1);
    chk("perr.count", char_count, 8'd0);
`ifdef RST_SKIP_INVALID_EN
    chk("skip.state", dbg_state, OUT);
    chk("skip.beat", {ctx_valid, ctx_last, ctx_out}, {1'b1, 1'b1, 16'h0000});
    step();
    chk("skip.done", {dbg_state, ctx_valid}, {DONE, 1'b0});
    step();
    chk("skip.idle", dbg_state, IDLE);
    chk("skip.sticky", err_ptx, 1'b1);
`else
    chk("abort.state", dbg_state, ERROR);
    chk("abort.ctx_valid", ctx_valid, 1'b0);
    chk("abort.ptx_ready", ptx_ready, 1'b0);
    step();
    chk("abort.stay", {dbg_state, err_ptx, ctx_valid}, {ERROR, 1'b1, 1'b0});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
